// File: rtl/a3_pkg.sv
// Encodings shared between the program counter stage and the instruction fetch unit.
package a3_pkg;

    localparam logic [7:0] CTL_OP_READ_ADDR = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifetch.sv
// Instruction fetch: reads four bytes from a byte-wide memory, assembles a
// little-endian 32-bit word and holds it until downstream accepts it.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a read-address opcode on the control bus
// ST_FETCH | requesting bytes base+0 .. base+3 from memory
// ST_HOLD  | word (or misalignment fault) presented, waiting for insn_ready
module ifetch
    import a3_pkg::*;
#(
    parameter logic [7:0] CTL_READ_ADDR = CTL_OP_READ_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ctl_op_in,
    input  logic [63:0] ctl_data_in,
    input  logic        flush,
    input  logic [7:0]  mem_data_in,
    input  logic        mem_ready,
    input  logic        insn_ready,
    output logic        pc_inhibit,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    output logic        insn_valid,
    output logic [31:0] insn_out,
    output logic [63:0] insn_addr,
    output logic        insn_fault
);

    fetch_state_t state, state_next;
    logic [63:0]  base;
    logic [1:0]   idx;
    logic         accept;
    logic         misaligned;
    logic         byte_taken;

    assign accept     = (state == ST_IDLE) && (ctl_op_in == CTL_READ_ADDR);
    assign misaligned = (ctl_data_in[1:0] != 2'b00);
    assign byte_taken = (state == ST_FETCH) && mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            base       <= '0;
            idx        <= '0;
            insn_out   <= '0;
            insn_addr  <= '0;
            insn_fault <= 1'b0;
        end else begin
            state <= state_next;
            if (flush) begin
                idx        <= '0;
                insn_fault <= 1'b0;
            end else if (accept) begin
                base       <= ctl_data_in;
                idx        <= '0;
                insn_out   <= '0;
                insn_addr  <= ctl_data_in;
                insn_fault <= misaligned;
            end else if (byte_taken) begin
                // idx rolls back to zero naturally after the fourth byte
                insn_out[{idx, 3'b000} +: 8] <= mem_data_in;
                idx                          <= idx + 2'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = misaligned ? ST_HOLD : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (byte_taken && (idx == 2'd3)) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (insn_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // flush overrides every other transition
        if (flush) begin
            state_next = ST_IDLE;
        end
    end

    assign pc_inhibit = (state != ST_IDLE);
    assign mem_req    = (state == ST_FETCH);
    assign mem_addr   = mem_req ? (base + {62'd0, idx}) : '0;
    assign insn_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: expected words are queued when a fetch is
// launched and compared when insn_valid rises.
module tb_ifetch;
    import a3_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ctl_op_in;
    logic [63:0] ctl_data_in;
    logic        flush;
    logic [7:0]  mem_data_in;
    logic        mem_ready;
    logic        insn_ready;
    logic        pc_inhibit;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        insn_valid;
    logic [31:0] insn_out;
    logic [63:0] insn_addr;
    logic        insn_fault;

    typedef struct {
        logic [31:0] word;
        logic [63:0] addr;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic prev_valid = 1'b0;

    ifetch #(.CTL_READ_ADDR(8'h02)) dut (
        .clk         (clk),
        .reset       (reset),
        .ctl_op_in   (ctl_op_in),
        .ctl_data_in (ctl_data_in),
        .flush       (flush),
        .mem_data_in (mem_data_in),
        .mem_ready   (mem_ready),
        .insn_ready  (insn_ready),
        .pc_inhibit  (pc_inhibit),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .insn_valid  (insn_valid),
        .insn_out    (insn_out),
        .insn_addr   (insn_addr),
        .insn_fault  (insn_fault)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // scoreboard consumer: compare on the rising edge of insn_valid
    always @(negedge clk) begin
        if (insn_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                chk_eq("sb_unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk_eq("sb_insn_out", {32'd0, insn_out}, {32'd0, e.word});
                chk_eq("sb_insn_addr", insn_addr, e.addr);
                chk_eq("sb_insn_fault", {63'd0, insn_fault}, {63'd0, e.fault});
            end
        end
        prev_valid = insn_valid;
    end

    // Launch one fetch and act as memory; valid_cyc is the cycle (1 = first
    // cycle after the accepting edge) in which insn_valid was first seen.
    task automatic run_fetch(input logic [63:0] addr, input logic [31:0] word,
                             input int waits, input int flush_byte, output int valid_cyc);
        int done = 0;
        int w = 0;
        valid_cyc = -1;
        @(negedge clk);
        ctl_op_in   = 8'h02;
        ctl_data_in = addr;
        @(posedge clk);
        @(negedge clk);
        ctl_op_in   = 8'h00;
        ctl_data_in = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (insn_valid) begin
                valid_cyc = cyc;
                break;
            end
            if (flush_byte >= 0 && done > flush_byte) break;
            mem_ready = 1'b0;
            flush     = 1'b0;
            if (mem_req) begin
                chk_eq("pc_inhibit_fetch", {63'd0, pc_inhibit}, 64'd1);
                chk_eq("mem_addr", mem_addr, addr + 64'(done));
                if (w < waits) begin
                    w++;
                end else begin
                    mem_ready   = 1'b1;
                    mem_data_in = word[8*done +: 8];
                    if (done == flush_byte) flush = 1'b1;
                    done++;
                    w = 0;
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        flush     = 1'b0;
    endtask

    // Stall downstream for n cycles (offering ignored opcodes), then accept.
    task automatic release_hold(input int n, input logic [31:0] word,
                                input logic [63:0] addr, input logic fault);
        for (int i = 0; i < n; i++) begin
            insn_ready  = 1'b0;
            ctl_op_in   = 8'h02;
            ctl_data_in = 64'h200;
            chk_eq("hold_valid", {63'd0, insn_valid}, 64'd1);
            chk_eq("hold_insn_out", {32'd0, insn_out}, {32'd0, word});
            chk_eq("hold_insn_addr", insn_addr, addr);
            chk_eq("hold_fault", {63'd0, insn_fault}, {63'd0, fault});
            chk_eq("hold_mem_req", {63'd0, mem_req}, 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        ctl_op_in   = 8'h00;
        ctl_data_in = '0;
        insn_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        insn_ready = 1'b0;
        chk_eq("release_valid", {63'd0, insn_valid}, 64'd0);
        chk_eq("release_pc_inhibit", {63'd0, pc_inhibit}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc;
        reset       = 1'b1;
        ctl_op_in   = '0;
        ctl_data_in = '0;
        flush       = 1'b0;
        mem_data_in = '0;
        mem_ready   = 1'b0;
        insn_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_pc_inhibit", {63'd0, pc_inhibit}, 64'd0);
        chk_eq("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk_eq("rst_mem_addr", mem_addr, 64'd0);
        chk_eq("rst_insn_valid", {63'd0, insn_valid}, 64'd0);
        chk_eq("rst_insn_out", {32'd0, insn_out}, 64'd0);
        chk_eq("rst_insn_addr", insn_addr, 64'd0);
        chk_eq("rst_insn_fault", {63'd0, insn_fault}, 64'd0);
        reset = 1'b0;

        // non-fetch opcode is ignored
        ctl_op_in = 8'h05;
        @(posedge clk);
        @(negedge clk);
        ctl_op_in = 8'h00;
        chk_eq("other_op_idle", {63'd0, pc_inhibit}, 64'd0);

        // basic zero-wait fetch
        sb.push_back('{word: 32'h00500013, addr: 64'h100, fault: 1'b0});
        run_fetch(64'h100, 32'h00500013, 0, -1, vc);
        chk_eq("valid_latency", 64'(vc), 64'd5);
        release_hold(0, 32'h00500013, 64'h100, 1'b0);

        // three wait states before every byte
        sb.push_back('{word: 32'h00500013, addr: 64'h100, fault: 1'b0});
        run_fetch(64'h100, 32'h00500013, 3, -1, vc);
        chk_eq("wait_completed", {63'd0, vc > 0}, 64'd1);
        release_hold(0, 32'h00500013, 64'h100, 1'b0);

        // misaligned address faults without touching memory
        sb.push_back('{word: 32'h0, addr: 64'h102, fault: 1'b1});
        run_fetch(64'h102, 32'h0, 0, -1, vc);
        chk_eq("misalign_latency", 64'(vc), 64'd1);
        chk_eq("misalign_mem_req", {63'd0, mem_req}, 64'd0);
        release_hold(2, 32'h0, 64'h102, 1'b1);

        // address wrap at the top of the 64-bit space
        sb.push_back('{word: 32'hDEADBEEF, addr: 64'hFFFF_FFFF_FFFF_FFFC, fault: 1'b0});
        run_fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'hDEADBEEF, 0, -1, vc);
        chk_eq("wrap_latency", 64'(vc), 64'd5);
        release_hold(0, 32'hDEADBEEF, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);

        // flush coincident with byte 2, then a clean fetch
        run_fetch(64'h100, 32'h11223344, 0, 2, vc);
        chk_eq("flush_valid", {63'd0, insn_valid}, 64'd0);
        chk_eq("flush_mem_req", {63'd0, mem_req}, 64'd0);
        chk_eq("flush_pc_inhibit", {63'd0, pc_inhibit}, 64'd0);
        sb.push_back('{word: 32'hCAFEF00D, addr: 64'h104, fault: 1'b0});
        run_fetch(64'h104, 32'hCAFEF00D, 0, -1, vc);
        chk_eq("post_flush_latency", 64'(vc), 64'd5);
        release_hold(0, 32'hCAFEF00D, 64'h104, 1'b0);

        // downstream backpressure for 10 cycles
        sb.push_back('{word: 32'h0BADC0DE, addr: 64'h108, fault: 1'b0});
        run_fetch(64'h108, 32'h0BADC0DE, 1, -1, vc);
        release_hold(10, 32'h0BADC0DE, 64'h108, 1'b0);

        // reset in the middle of a fetch
        @(negedge clk);
        ctl_op_in   = 8'h02;
        ctl_data_in = 64'h300;
        @(posedge clk);
        @(negedge clk);
        ctl_op_in   = 8'h00;
        ctl_data_in = '0;
        chk_eq("midrst_mem_req_before", {63'd0, mem_req}, 64'd1);
        mem_ready   = 1'b1;
        mem_data_in = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_eq("midrst_mem_req", {63'd0, mem_req}, 64'd0);
        chk_eq("midrst_mem_addr", mem_addr, 64'd0);
        chk_eq("midrst_pc_inhibit", {63'd0, pc_inhibit}, 64'd0);
        chk_eq("midrst_insn_out", {32'd0, insn_out}, 64'd0);
        chk_eq("midrst_insn_addr", insn_addr, 64'd0);
        chk_eq("midrst_insn_valid", {63'd0, insn_valid}, 64'd0);
        chk_eq("midrst_insn_fault", {63'd0, insn_fault}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk_eq("after_rst_mem_req", {63'd0, mem_req}, 64'd0);
        end

        chk_eq("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
